// File: rtl/alu_rmw_sequencer.sv
// alu_rmw_sequencer: sequences a CB-prefix (HL) read-modify-write instruction.
// The operand byte is read from memory at HL, passed once through an external
// ALU, and written back (except for BIT). The sequencer also returns the flags
// that the CPU should write back.
// Optional feature: define ALU_RMW_TIMEOUT_EN to abort a memory phase that has
// waited WAIT_LIMIT cycles for memAck. The abort raises a one-cycle err pulse.
// Without the macro the sequencer waits indefinitely and err is tied low.
module alu_rmw_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cbOp,
    input  logic [15:0] hl,
    input  logic [3:0]  fIn,
    output logic [15:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic [7:0]  memDataOut,
    input  logic [7:0]  memDataIn,
    input  logic        memAck,
    output logic [7:0]  aluOp,
    output logic [15:0] aluX,
    output logic [15:0] aluY,
    output logic [3:0]  aluFIn,
    input  logic [15:0] aluO,
    input  logic [3:0]  aluFOut,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        fWrite,
    output logic [3:0]  fOut
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] hl_r;
    logic [3:0]  fin_r;
    logic [4:0]  op_r;        // cbOp[7:3]: group and bit/sub-op field
    logic [7:0]  result_r;
    logic        carry_r;

    logic        is_bit_s;
    logic        is_resset_s;
    logic        is_swap_s;
    logic [3:0]  shift_flags_s;
    logic        wait_expired_s;
    logic        unused_s;

    // Map the latched CB opcode fields onto the ALU operation code.
    function automatic logic [7:0] alu_decode(input logic [4:0] op);
        logic [7:0] code;
        case (op[4:3])
            2'b00: begin
                case (op[2:0])
                    3'd0:    code = 8'h10;   // RLC
                    3'd1:    code = 8'h11;   // RRC
                    3'd2:    code = 8'h12;   // RL
                    3'd3:    code = 8'h13;   // RR
                    3'd4:    code = 8'h24;   // SLA
                    3'd5:    code = 8'h25;   // SRA
                    3'd6:    code = 8'h27;   // SWAP
                    3'd7:    code = 8'h26;   // SRL
                    default: code = 8'h00;
                endcase
            end
            2'b01:   code = {4'h3, 1'b0, op[2:0]};   // BIT b
            2'b10:   code = {4'h4, 1'b0, op[2:0]};   // RES b
            2'b11:   code = {4'h5, 1'b0, op[2:0]};   // SET b
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    assign is_bit_s    = (op_r[4:3] == 2'b01);
    assign is_resset_s = op_r[4];
    assign is_swap_s   = (op_r == 5'b00110);

    // Shift/rotate/swap flags: Z from the written byte, N=H=0, C from the ALU
    // except SWAP, which always clears carry.
    assign shift_flags_s = {(result_r == 8'h00), 1'b0, 1'b0, carry_r & ~is_swap_s};

    // High ALU byte and the unused flag bits are not needed for byte operations.
    assign unused_s = ^{aluO[15:8], aluFOut[2:1], 8'(WAIT_LIMIT)};

`ifdef ALU_RMW_TIMEOUT_EN
    localparam logic [7:0] LIMIT_LAST = 8'(WAIT_LIMIT - 1);

    logic [7:0] wait_cnt_r;

    assign wait_expired_s = (wait_cnt_r == LIMIT_LAST);

    // Count un-acknowledged cycles of the current memory phase and flag the abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
            err        <= 1'b0;
        end else if ((state_r == READ) || (state_r == WRITE)) begin
            if (memAck) begin
                wait_cnt_r <= 8'd0;
                err        <= 1'b0;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
                err        <= wait_expired_s;
            end
        end else begin
            wait_cnt_r <= 8'd0;
            err        <= 1'b0;
        end
    end
`else
    assign wait_expired_s = 1'b0;
    assign err            = 1'b0;
`endif

    // Main sequencer: state and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            hl_r       <= 16'h0000;
            fin_r      <= 4'h0;
            op_r       <= 5'b00000;
            result_r   <= 8'h00;
            carry_r    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fWrite     <= 1'b0;
            fOut       <= 4'h0;
            memAddr    <= 16'h0000;
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            memDataOut <= 8'h00;
            aluOp      <= 8'h00;
            aluX       <= 16'h0000;
            aluY       <= 16'h0000;
            aluFIn     <= 4'h0;
        end else begin
            done   <= 1'b0;
            fWrite <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && (cbOp[2:0] == 3'b110)) begin
                        op_r    <= cbOp[7:3];
                        hl_r    <= hl;
                        fin_r   <= fIn;
                        memAddr <= hl;
                        memRead <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= READ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    if (memAck) begin
                        memRead <= 1'b0;
                        aluOp   <= alu_decode(op_r);
                        aluX    <= {8'h00, memDataIn};
                        aluY    <= 16'h0000;
                        aluFIn  <= fin_r;
                        state_r <= EXEC;
                    end else if (wait_expired_s) begin
                        memRead <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= READ;
                    end
                end
                EXEC: begin
                    aluOp    <= 8'h00;
                    result_r <= aluO[7:0];
                    carry_r  <= aluFOut[0];
                    if (is_bit_s) begin
                        // BIT: Z from the ALU, N=0, H=1, carry preserved.
                        fOut    <= {aluFOut[3], 1'b0, 1'b1, fin_r[0]};
                        fWrite  <= 1'b1;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        memAddr    <= hl_r;
                        memDataOut <= aluO[7:0];
                        memWrite   <= 1'b1;
                        state_r    <= WRITE;
                    end
                end
                WRITE: begin
                    if (memAck) begin
                        memWrite <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= DONE;
                        if (!is_resset_s) begin
                            fOut   <= shift_flags_s;
                            fWrite <= 1'b1;
                        end else begin
                            fWrite <= 1'b0;
                        end
                    end else if (wait_expired_s) begin
                        memWrite <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    memRead  <= 1'b0;
                    memWrite <= 1'b0;
                    aluOp    <= 8'h00;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Scoreboard bench for alu_rmw_sequencer: directed CB (HL) vectors, a memory
// responder with programmable ack delay, and a behavioural ALU.
module tb_alu_rmw_sequencer;

    localparam int WL = 4;

    logic        clk;
    logic        reset, start;
    logic [7:0]  cbOp;
    logic [15:0] hl;
    logic [3:0]  fIn;
    logic [15:0] memAddr;
    logic        memRead, memWrite;
    logic [7:0]  memDataOut, memDataIn;
    logic        memAck;
    logic [7:0]  aluOp;
    logic [15:0] aluX, aluY, aluO;
    logic [3:0]  aluFIn, aluFOut;
    logic        busy, done, err, fWrite;
    logic [3:0]  fOut;

    alu_rmw_sequencer #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .start(start), .cbOp(cbOp), .hl(hl), .fIn(fIn),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
        .memDataOut(memDataOut), .memDataIn(memDataIn), .memAck(memAck),
        .aluOp(aluOp), .aluX(aluX), .aluY(aluY), .aluFIn(aluFIn),
        .aluO(aluO), .aluFOut(aluFOut),
        .busy(busy), .done(done), .err(err), .fWrite(fWrite), .fOut(fOut)
    );

    typedef struct packed {
        logic [3:0]  fo;
        logic        fw;
        logic [31:0] cyc;
    } done_t;

    int          checks = 0;
    int          fails  = 0;
    int unsigned cnt    = 0;
    logic [7:0]  mem_val   = 8'h00;
    int          ack_delay = 0;
    logic [3:0]  last_fout = 4'h0;
    logic        mon_en    = 1'b0;
    int          err_pending = 0;
    int unsigned err_cyc     = 0;

    logic [15:0] rd_q[$];
    logic [23:0] wr_q[$];
    logic [43:0] alu_q[$];
    done_t       done_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) cnt <= cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: returns {flags, 16-bit result}. High byte is junk.
    // SWAP reports a stray carry, which the sequencer must not pass through.
    function automatic logic [19:0] alu_model(input logic [7:0] op, input logic [7:0] x,
                                              input logic [3:0] fi);
        logic [7:0] r, mask;
        logic c, h, z;
        mask = 8'h01 << op[2:0];
        c = 1'b0; h = 1'b0; r = x;
        case (op)
            8'h10: begin r = {x[6:0], x[7]};  c = x[7]; end
            8'h11: begin r = {x[0], x[7:1]};  c = x[0]; end
            8'h12: begin r = {x[6:0], fi[0]}; c = x[7]; end
            8'h13: begin r = {fi[0], x[7:1]}; c = x[0]; end
            8'h24: begin r = {x[6:0], 1'b0};  c = x[7]; end
            8'h25: begin r = {x[7], x[7:1]};  c = x[0]; end
            8'h26: begin r = {1'b0, x[7:1]};  c = x[0]; end
            8'h27: begin r = {x[3:0], x[7:4]}; c = 1'b1; end
            default: begin
                case (op[7:4])
                    4'h3:    begin r = x; h = 1'b1; c = fi[0]; end
                    4'h4:    r = x & ~mask;
                    4'h5:    r = x | mask;
                    default: r = 8'h00;
                endcase
            end
        endcase
        z = (op[7:4] == 4'h3) ? ((x & mask) == 8'h00) : (r == 8'h00);
        return {z, 1'b0, h, c, 8'hA5, r};
    endfunction

    // Memory responder and ALU, updated shortly after each rising edge.
    initial begin
        logic [19:0] a;
        int wcnt;
        memAck = 1'b0; memDataIn = 8'h00; aluO = 16'h0000; aluFOut = 4'h0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (memRead === 1'b1 || memWrite === 1'b1) begin
                if (wcnt >= ack_delay) begin
                    memAck = 1'b1;
                    memDataIn = mem_val;
                end else begin
                    memAck = 1'b0;
                    wcnt++;
                end
            end else begin
                memAck = 1'b0;
                wcnt = 0;
            end
            a = alu_model(aluOp, aluX[7:0], aluFIn);
            aluFOut = a[19:16];
            aluO    = a[15:0];
        end
    end

    // Monitor: pops expected transactions as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("rd_wr_exclusive", {memRead, memWrite} == 2'b11, 1'b0);
                if (memRead && memAck) begin
                    check("rd_expected", rd_q.size() != 0, 1'b1);
                    if (rd_q.size() != 0) check("rd_addr", memAddr, rd_q.pop_front());
                end
                if (memWrite && memAck) begin
                    check("wr_expected", wr_q.size() != 0, 1'b1);
                    if (wr_q.size() != 0) check("wr_addr_data", {memAddr, memDataOut}, wr_q.pop_front());
                end
                if (aluOp != 8'h00) begin
                    check("alu_expected", alu_q.size() != 0, 1'b1);
                    if (alu_q.size() != 0) check("alu_port", {aluOp, aluX, aluY, aluFIn}, alu_q.pop_front());
                end
                if (done) begin
                    check("done_expected", done_q.size() != 0, 1'b1);
                    if (done_q.size() != 0) begin
                        done_t e;
                        e = done_q.pop_front();
                        check("done_cycle", cnt, e.cyc);
                        check("fwrite", fWrite, e.fw);
                        check("busy_in_done", busy, 1'b1);
                        if (e.fw) begin
                            check("fout", fOut, e.fo);
                            last_fout = e.fo;
                        end
                    end
                end else begin
                    check("fwrite_without_done", fWrite, 1'b0);
                end
                if (err) begin
                    check("err_expected", err_pending != 0, 1'b1);
                    if (err_pending != 0) begin
                        check("err_cycle", cnt, err_cyc);
                        check("busy_at_err", busy, 1'b0);
                        err_pending--;
                    end
                end
                if (!busy) check("fout_hold", fOut, last_fout);
            end
        end
    end

    task automatic reset_check(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, fWrite, memRead, memWrite}, 6'b000000);
        check({tag, "_addr"}, memAddr, 16'h0000);
        check({tag, "_wdata"}, memDataOut, 8'h00);
        check({tag, "_aluop"}, aluOp, 8'h00);
        check({tag, "_fout"}, fOut, 4'h0);
    endtask

    task automatic wait_idle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        check({tag, "_idle_within_budget"}, idle, 1'b1);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [15:0] a, input logic [3:0] fi,
                          input logic [7:0] m, input int dly, input logic wr,
                          input logic [7:0] wd, input logic [7:0] aop,
                          input logic [3:0] fo, input logic fw, input int lat,
                          input logic poke);
        done_t e;
        int unsigned s;
        mem_val = m;
        ack_delay = dly;
        rd_q.push_back(a);
        if (wr) wr_q.push_back({a, wd});
        alu_q.push_back({aop, 8'h00, m, 16'h0000, fi});
        @(negedge clk);
        start = 1'b1; cbOp = op; hl = a; fIn = fi;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cnt;
        e.fo = fo; e.fw = fw; e.cyc = s + lat - 1;
        done_q.push_back(e);
        if (poke) begin
            // A second request while busy must be ignored; inputs are latched.
            @(negedge clk);
            start = 1'b1; cbOp = 8'h0E; hl = 16'h1234; fIn = 4'hF;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_idle("op");
    endtask

    initial begin
        logic seen;
        reset = 1'b1; start = 1'b0; cbOp = 8'h00; hl = 16'h0000; fIn = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_check("reset");
        last_fout = 4'h0;
        mon_en = 1'b1;

        // Opcode with cbOp[2:0] != 110 is not accepted.
        @(negedge clk);
        start = 1'b1; cbOp = 8'h07; hl = 16'hBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("ignored_start_busy", busy, 1'b0);
        check("ignored_start_read", memRead, 1'b0);

        //     op     hl        fIn   mem    dly wr    wdata  aluOp  fOut  fW    lat poke
        run_op(8'h06, 16'hC000, 4'h0, 8'h85, 0, 1'b1, 8'h0B, 8'h10, 4'h1, 1'b1, 4,  1'b0); // RLC
        run_op(8'h36, 16'hC001, 4'h0, 8'hF0, 0, 1'b1, 8'h0F, 8'h27, 4'h0, 1'b1, 4,  1'b0); // SWAP
        run_op(8'h7E, 16'hC002, 4'h1, 8'h7F, 0, 1'b0, 8'h00, 8'h37, 4'hB, 1'b1, 3,  1'b0); // BIT 7
        run_op(8'hC6, 16'hC003, 4'h0, 8'h00, 3, 1'b1, 8'h01, 8'h50, 4'h0, 1'b0, 10, 1'b0); // SET 0
        run_op(8'h1E, 16'h8000, 4'h1, 8'h01, 1, 1'b1, 8'h80, 8'h13, 4'h1, 1'b1, 6,  1'b1); // RR
        run_op(8'h26, 16'h8001, 4'h0, 8'h80, 0, 1'b1, 8'h00, 8'h24, 4'h9, 1'b1, 4,  1'b0); // SLA
        run_op(8'h2E, 16'h8002, 4'h0, 8'h81, 0, 1'b1, 8'hC0, 8'h25, 4'h1, 1'b1, 4,  1'b0); // SRA
        run_op(8'h3E, 16'h8003, 4'h0, 8'h01, 0, 1'b1, 8'h00, 8'h26, 4'h9, 1'b1, 4,  1'b0); // SRL
        run_op(8'h46, 16'h8004, 4'hE, 8'h01, 0, 1'b0, 8'h00, 8'h30, 4'h2, 1'b1, 3,  1'b0); // BIT 0
        run_op(8'h9E, 16'h8005, 4'h0, 8'hFF, 2, 1'b1, 8'hF7, 8'h43, 4'h0, 1'b0, 8,  1'b0); // RES 3
        run_op(8'h16, 16'h8006, 4'h1, 8'h00, 0, 1'b1, 8'h01, 8'h12, 4'h0, 1'b1, 4,  1'b0); // RL
        run_op(8'h0E, 16'h8007, 4'h0, 8'h01, 0, 1'b1, 8'h80, 8'h11, 4'h1, 1'b1, 4,  1'b0); // RRC

        // Reset while WRITE is pending: write abandoned, no done.
        mem_val = 8'h33;
        ack_delay = 2;
        rd_q.push_back(16'hD000);
        alu_q.push_back({8'h10, 16'h0033, 16'h0000, 4'h0});
        @(negedge clk);
        start = 1'b1; cbOp = 8'h06; hl = 16'hD000; fIn = 4'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = memWrite;
        end
        check("mid_write_reached", seen, 1'b1);
        reset = 1'b1;
        last_fout = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_check("mid_write_reset");
        repeat (8) @(negedge clk);

        // Recovery after the abandoned write.
        run_op(8'h06, 16'hC000, 4'h0, 8'h85, 0, 1'b1, 8'h0B, 8'h10, 4'h1, 1'b1, 4, 1'b0);

`ifdef ALU_RMW_TIMEOUT_EN
        // memAck never arrives: abort after WL READ cycles with an err pulse.
        ack_delay = 1000;
        @(negedge clk);
        start = 1'b1; cbOp = 8'h06; hl = 16'hC100; fIn = 4'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        err_cyc = cnt + WL;
        err_pending = 1;
        repeat (WL + 4) @(negedge clk);
        check("timeout_err_seen", err_pending, 0);
        check("timeout_idle", busy, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("alu_q_drained", alu_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_rmw_sequencer.md
ALU_RMW_SEQUENCER -- requirements
Module: alu_rmw_sequencer

Interface
REQ-001 Parameter: WAIT_LIMIT, 15, max cycles to wait for memAck in one memory phase (1..255).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  request pulse, sampled in IDLE only.
REQ-005 cbOp  in  8  CB-prefix opcode.
REQ-006 hl  in  16  operand address, latched on accepted start.
REQ-007 fIn  in  4  current flags {Z,N,H,C}, latched on accepted start.
REQ-008 memAddr/memRead/memWrite/memDataOut  out  16/1/1/8  memory request; memDataIn in 8; memAck in 1.
REQ-009 aluOp  out  8;  aluX, aluY  out  16;  aluFIn  out  4;  aluO  in  16;  aluFOut  in  4  ALU port.
REQ-010 busy/done/err/fWrite  out  1 each;  fOut  out  4  flags to write back.

Function
REQ-011 Accept start only in IDLE with cbOp[2:0]==3'b110; otherwise ignore, no state change.
REQ-012 States IDLE->READ->EXEC->(WRITE)->DONE->IDLE; busy=1 in every state except IDLE.
REQ-013 READ: memAddr=latched hl, memRead=1 held until a cycle with memAck=1; memDataIn captured that cycle; next EXEC.
REQ-014 EXEC (one cycle): aluX={8'h00,operand}, aluY=16'h0000, aluFIn=latched fIn; aluO[7:0] and aluFOut registered.
REQ-015 aluOp decode: cbOp[7:6]=00, cbOp[5:3]=0..7 -> 10,11,12,13,24,25,27,26 (RLC,RRC,RL,RR,SLA,SRA,SWAP,SRL); 01 -> {4'h3,1'b0,b}; 10 -> {4'h4,1'b0,b}; 11 -> {4'h5,1'b0,b}; b=cbOp[5:3]; aluOp=8'h00 outside EXEC.
REQ-016 BIT group goes EXEC->DONE; all other groups EXEC->WRITE.
REQ-017 WRITE: memAddr=hl, memWrite=1, memDataOut=registered result, held stable until memAck=1; next DONE.
REQ-018 DONE (one cycle): done=1; fWrite=1 for shift/rotate/swap and BIT, 0 for RES/SET.
REQ-019 Shift/rotate/swap flags: fOut={result==0,0,0,aluFOut[0]}; SWAP forces C=0.
REQ-020 BIT flags: fOut={aluFOut[3],0,1,latched fIn[0]} (carry preserved).
REQ-021 fOut held from DONE until next accepted start; memRead/memWrite never both 1.
REQ-022 Zero-wait memory (memAck same cycle as request): done 4 cycles after start edge (3 for BIT).
REQ-023 start during busy ignored; memAck in IDLE/EXEC/DONE ignored.

Reset
REQ-024 reset=1 at an edge forces IDLE from any state; next cycle busy=done=err=fWrite=memRead=memWrite=0, memAddr=0, memDataOut=0, aluOp=0, fOut=0.
REQ-025 Reset mid-WRITE abandons the write; no done, no fWrite.

Configuration
REQ-026 Macro ALU_RMW_TIMEOUT_EN defined: wait counter clears on entering READ/WRITE, increments per cycle without memAck; at WAIT_LIMIT go IDLE, err=1 for one cycle, no done/fWrite.
REQ-027 Macro undefined: no counter, waits indefinitely, err tied 0.

Verification
REQ-028 cbOp=8'h06, hl=C000, mem=85, fIn=0, zero-wait -> read C000, write 0B, fOut=0001, done at cycle 4.
REQ-029 cbOp=8'h36, mem=F0 -> write 0F, fOut=0000, fWrite=1.
REQ-030 cbOp=8'h7E, mem=7F, fIn=0001 -> no memWrite, fOut=1011, done at cycle 3.
REQ-031 cbOp=8'hC6, mem=00, memAck delayed 3 cycles each phase -> write 01, fWrite=0, done at cycle 10.
REQ-032 TIMEOUT_EN, WAIT_LIMIT=4, memAck never -> err pulse after 4 READ cycles, busy=0; reset asserted mid-WRITE -> memWrite=0 next cycle, no done.
